// File: rtl/period_meter.sv
// period_meter: measures one sig_in period in clk cycles per arm request, saturating on overflow.
// Defining PERIOD_METER_BCD_EN adds a sequential double-dabble stage and the bcd output.
module period_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             arm,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] period,
`ifdef PERIOD_METER_BCD_EN
    output logic [11:0]      bcd,
`endif
    output logic             overflow
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EDGE,
        COUNT,
`ifdef PERIOD_METER_BCD_EN
        CONVERT,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             sig_edge, cnt_full;

`ifdef PERIOD_METER_BCD_EN
    localparam logic [WIDTH-1:0] LAST_BIT = WIDTH'(WIDTH - 1);
    localparam state_t RESULT = CONVERT;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [11:0]      dd_q, dd_d, dd_adj;
    logic [11:0]      bcd_q, bcd_d;
    if (WIDTH > 9) begin : g_width_check
        $error("period_meter: WIDTH must be <= 9 when PERIOD_METER_BCD_EN is defined");
    end
`else
    localparam state_t RESULT = DONE;
`endif

    assign sig_edge = sync_q[1] & ~sync_q[2];
    assign cnt_full = cnt_q == CNT_MAX;

    always_comb begin
        sync_d   = {sync_q[1:0], sig_in};
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        ovf_d    = ovf_q;
        valid_d  = state_q == DONE;
`ifdef PERIOD_METER_BCD_EN
        sh_d     = sh_q;
        dd_d     = dd_q;
        dd_adj   = dd_q;
        bcd_d    = bcd_q;
`endif
        case (state_q)
            IDLE: state_d = arm ? WAIT_EDGE : IDLE;
            WAIT_EDGE: begin
                cnt_d   = sig_edge ? '0 : cnt_q;
                state_d = sig_edge ? COUNT : WAIT_EDGE;
            end
            COUNT: begin
                cnt_d = cnt_q + 1'b1;
                // an edge landing on the full count still reports saturation
                if (cnt_full || sig_edge) begin
                    period_d = cnt_full ? CNT_MAX : cnt_q + 1'b1;
                    ovf_d    = cnt_full;
                    state_d  = RESULT;
`ifdef PERIOD_METER_BCD_EN
                    cnt_d    = '0;
                    sh_d     = period_d;
                    dd_d     = '0;
`endif
                end
            end
`ifdef PERIOD_METER_BCD_EN
            CONVERT: begin
                for (int i = 0; i < 3; i++)
                    dd_adj[4*i +: 4] = (dd_q[4*i +: 4] > 4'd4) ? dd_q[4*i +: 4] + 4'd3 : dd_q[4*i +: 4];
                {dd_d, sh_d} = {dd_adj, sh_q} << 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_BIT) ? DONE : CONVERT;
            end
`endif
            DONE: begin
                state_d = IDLE;
`ifdef PERIOD_METER_BCD_EN
                bcd_d   = dd_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
`ifdef PERIOD_METER_BCD_EN
            sh_q     <= '0;
            dd_q     <= '0;
            bcd_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
`ifdef PERIOD_METER_BCD_EN
            sh_q     <= sh_d;
            dd_q     <= dd_d;
            bcd_q    <= bcd_d;
`endif
        end
    end

    assign busy     = state_q != IDLE;
    assign valid    = valid_q;
    assign period   = period_q;
    assign overflow = ovf_q;
`ifdef PERIOD_METER_BCD_EN
    assign bcd      = bcd_q;
`endif
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized bench for period_meter against a rise-time based reference model.
// Define PERIOD_METER_BCD_EN here too to check the bcd output and longer result latency.
module tb_period_meter;
    localparam int W    = 8;
    localparam int MAXV = 2**W - 1;
`ifdef PERIOD_METER_BCD_EN
    localparam int LAT  = W + 1;
`else
    localparam int LAT  = 1;
`endif

    typedef struct {
        int c;
        int p;
        bit o;
        int b;
        bit busy;
    } vrec_t;

    logic         clk, rst, sig_in, arm, busy, valid, overflow;
    logic [W-1:0] period;
`ifdef PERIOD_METER_BCD_EN
    logic [11:0]  bcd;
`endif

    int    n_tests, n_fail, cyc, nvalid, exp_valids;
    int    hi_len, lo_len, ph_left;
    bit    wave_on;
    int    rises[$];
    vrec_t vq[$];

    period_meter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .arm(arm),
        .busy(busy),
        .valid(valid),
        .period(period),
`ifdef PERIOD_METER_BCD_EN
        .bcd(bcd),
`endif
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int to_bcd(input int p);
        return ((p / 100) % 10) * 256 + ((p / 10) % 10) * 16 + p % 10;
    endfunction

    function automatic int rise_idx(input int t);
        for (int i = 0; i < rises.size(); i++)
            if (rises[i] >= t) return i;
        return -1;
    endfunction

    // one clock: sample outputs just after the edge, then update the wave and drop arm
    task automatic step();
        vrec_t v;
        @(posedge clk);
        #1;
        cyc++;
        arm = 1'b0;
        if (valid) begin
            nvalid++;
            v.c = cyc;
            v.p = int'(period);
            v.o = overflow;
            v.busy = busy;
`ifdef PERIOD_METER_BCD_EN
            v.b = int'(bcd);
`else
            v.b = 0;
`endif
            vq.push_back(v);
        end
        if (wave_on) begin
            if (ph_left == 0) begin
                sig_in = ~sig_in;
                if (sig_in) rises.push_back(cyc);
                ph_left = (sig_in ? hi_len : lo_len) - 1;
            end else begin
                ph_left--;
            end
        end
    endtask

    task automatic set_wave(input int h, input int l);
        hi_len = h;
        lo_len = l;
        ph_left = 0;
        repeat (2 * (h + l) + 4) step();
    endtask

    // A rise driven after edge r reaches the FSM as an edge at edge r+3; the arm set
    // after edge a is sampled at a+1, so the first usable rise is the first one >= a-1.
    task automatic measure(input bit extra, output int got_p, output bit got_o);
        int    a, n, i0, r0, r1, p, ev;
        bit    ov;
        vrec_t v;
        check("no_stray_valid", vq.size(), 0);
        vq.delete();
        got_p = -1;
        got_o = 1'b0;
        a = cyc;
        arm = 1'b1;
        step();
        check("busy_rise", busy, 1);
        if (extra) begin
            repeat (3) step();
            arm = 1'b1;
            step();
        end
        n = 0;
        while (vq.size() == 0 && n < 800) begin
            step();
            n++;
        end
        exp_valids++;
        check("valid_seen", vq.size() > 0, 1);
        if (vq.size() == 0) return;
        v = vq.pop_front();
        i0 = rise_idx(a - 1);
        check("first_edge_exists", i0 >= 0, 1);
        if (i0 < 0) return;
        r0 = rises[i0];
        r1 = (i0 + 1 < rises.size()) ? rises[i0 + 1] : r0 + 100000;
        ov = (r1 - r0) > MAXV;
        p  = ov ? MAXV : r1 - r0;
        ev = ov ? r0 + 3 + (MAXV + 1) + LAT : r1 + 3 + LAT;
        check("valid_cycle", v.c, ev);
        check("period", v.p, p);
        check("overflow", v.o, ov);
        check("busy_at_valid", v.busy, 0);
`ifdef PERIOD_METER_BCD_EN
        check("bcd", v.b, to_bcd(p));
`endif
        got_p = v.p;
        got_o = v.o;
    endtask

    initial begin
        int  gp, n, a, i0;
        bit  go;
        n_tests = 0; n_fail = 0; cyc = 0; nvalid = 0; exp_valids = 0;
        rst = 1'b1; arm = 1'b0; sig_in = 1'b0;
        hi_len = 1; lo_len = 1; ph_left = 0; wave_on = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (i == 2) arm = 1'b1;
            step();
        end
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_period", period, 0);
        check("rst_overflow", overflow, 0);
`ifdef PERIOD_METER_BCD_EN
        check("rst_bcd", bcd, 0);
`endif
        rst = 1'b0;
        repeat (3) step();
        check("rst_arm_ignored", busy, 0);
        check("rst_no_valid", nvalid, 0);

        set_wave(113, 113);
        measure(1'b0, gp, go);
        check("nominal_226", gp, 226);

        set_wave(150, 150);
        measure(1'b0, gp, go);
        check("ovf_period_255", gp, 255);
        check("ovf_flag", go, 1);

        set_wave(128, 127);
        measure(1'b0, gp, go);
        check("p255_no_ovf", go, 0);
        set_wave(128, 128);
        measure(1'b0, gp, go);
        check("p256_ovf", go, 1);

        set_wave(1, 1);
        measure(1'b0, gp, go);
        check("min_period_2", gp, 2);

        set_wave(60, 40);
        measure(1'b1, gp, go);
        check("rearm_period_100", gp, 100);

        set_wave(30, 50);
        n = 0;
        while (!(rises.size() > 0 && rises[$] == cyc) && n < 200) begin
            step();
            n++;
        end
        step();
        step();
        measure(1'b0, gp, go);
        check("coincident_period_80", gp, 80);

        set_wave(113, 113);
        vq.delete();
        a = cyc;
        arm = 1'b1;
        step();
        n = 0;
        i0 = rise_idx(a - 1);
        while ((i0 < 0 || cyc < rises[i0] + 53) && n < 800) begin
            step();
            n++;
            i0 = rise_idx(a - 1);
        end
        check("mid_count_reached", n < 800, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_period", period, 0);
        repeat (500) step();
        check("mid_rst_no_valid", vq.size(), 0);
        measure(1'b0, gp, go);
        check("after_rst_226", gp, 226);

        set_wave(50, 50);
        for (int k = 0; k < 4; k++) begin
            measure(1'b0, gp, go);
            check("b2b_period_100", gp, 100);
        end

        for (int k = 0; k < 8; k++) begin
            hi_len = $urandom_range(1, 140);
            lo_len = $urandom_range(1, 140);
            repeat ($urandom_range(0, 40)) step();
            measure(1'b0, gp, go);
        end

        repeat (600) step();
        check("valid_count", nvalid, exp_valids);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of a slow square wave, such as the divided `tff_out` toggle of the preset counter, in system clock cycles. It is the receive end of the divider chain: the divider turns a count into a toggle rate, and this block turns the toggle rate back into a count that the duration display can show. It measures one period per `arm` request and reports either a binary count or a saturated overflow.

## Interface
Parameters:
- `WIDTH`, default 8: width of the period counter and the result.

Ports:
- `clk`, input, 1: system clock. Everything runs on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `sig_in`, input, 1: measured signal, asynchronous to `clk`.
- `arm`, input, 1: single-cycle request to start one measurement.
- `busy`, output, 1: high from acceptance of `arm` until `valid`.
- `valid`, output, 1: single-cycle pulse when a new result is on `period`.
- `period`, output, WIDTH: measured period in clk cycles. Held until the next `valid`.
- `overflow`, output, 1: the result saturated. Updated together with `period`.
- `bcd`, output, 12: three BCD digits of `period`. Present only with `PERIOD_METER_BCD_EN`.

## Operation
- `sig_in` passes through a 2-FF synchronizer, then a third register. The rising-edge strobe `edge` is `s2 & ~s3`.
- States:
  - IDLE: `busy`=0. On `arm`, go to WAIT_EDGE.
  - WAIT_EDGE: on `edge`, clear `cnt` to 0 and go to COUNT.
  - COUNT: `cnt` increments every cycle.
    - On `edge`: `period` <= `cnt`+1, `overflow` <= 0, go to DONE (no macro) or CONVERT (with macro).
    - If `cnt` = 2^WIDTH−1 and there is no `edge`: `period` <= all ones, `overflow` <= 1, go to the same next state.
  - CONVERT (macro only): sequential double-dabble, one bit per cycle for WIDTH cycles, then go to DONE.
  - DONE: pulse `valid` for one cycle, then return to IDLE.
- Result: `period` = t1 − t0, where t0 and t1 are the cycles in which the two consecutive `edge` strobes occur.
- The minimum measurable period is 2 cycles.
- `arm` is ignored whenever `busy`=1.
- An `edge` in the same cycle as `arm` is not taken as the first edge. The first edge must occur in WAIT_EDGE.
- WAIT_EDGE has no timeout. A stuck `sig_in` keeps the block waiting until `rst`.

## Timing
- Reset values: state IDLE, `busy`=0, `valid`=0, `period`=0, `overflow`=0, `bcd`=0, `cnt`=0, synchronizer registers 0.
- A `rst` during any state returns to IDLE on the next edge, with no `valid` and the outputs cleared.
- `busy` rises the cycle after `arm` is sampled.
- The `edge` strobe follows a `sig_in` rise by 2–3 clk cycles. The latency is identical for both edges, so it cancels in `period`.
- `valid` latency from the second `edge`:
  - Without the macro: 2 cycles. `period` is registered in cycle +1 and `valid` is high in cycle +2.
  - With the macro: WIDTH+2 cycles.
- `busy` falls in the same cycle that `valid` is high.
- `period` and `overflow` are stable from their update through `valid` and until the next result.
- Overflow: the saturation decision happens in the cycle where `cnt` = 2^WIDTH−1. An `edge` in that same cycle takes priority and gives `period` = 2^WIDTH with truncation, which is disallowed. Precedence is therefore fixed as follows: with `cnt` at maximum, an `edge` still reports overflow.

## Configuration
- `PERIOD_METER_BCD_EN` defined:
  - Adds the CONVERT state and the `bcd` port.
  - `bcd` is the 3-digit BCD of `period`; overflow gives BCD of 2^WIDTH−1.
  - `bcd` updates together with `valid`.
  - WIDTH must be ≤ 9; the elaboration check is `$error`.
- Not defined: no `bcd` port, no CONVERT state, and 2-cycle result latency.

## Test plan
- Reset: `rst` held for 5 cycles with `sig_in` toggling and `arm` pulsed -> all outputs 0, `busy`=0, and no `valid`.
- Nominal: WIDTH=8, `sig_in` toggles every 113 clk (count113 pattern), `arm` pulsed once -> exactly one `valid`, `period`=226, `overflow`=0, and `bcd`=0x226 with the macro.
- Overflow: WIDTH=8, `sig_in` period 300 clk -> `period`=255, `overflow`=1, `valid` 256 cycles after the first `edge` plus the pipeline, and `bcd`=0x255.
- Min/edge cases:
  - A 2-clk period gives `period`=2.
  - An `arm` pulse while `busy` is ignored and produces only one `valid`.
  - An `edge` coincident with `arm` is skipped: the next two edges define the result.
- Reset mid-measure: `rst` in COUNT -> `busy`=0 next cycle, no `valid`. A following `arm` measures correctly at 226.
- Back-to-back: `arm` on the cycle after `valid`, repeated 4 times with period 100 -> four `valid` pulses, each with `period`=100.
